// File: rtl/maxpool_rstl_streamer.sv
// Streams the pooled-result memory to the dense stage: sequenced reads, offset add, 2-deep skid FIFO.
// Define MAXPOOL_STREAM_SAT_EN to clamp the offset sum instead of wrapping it.
module maxpool_rstl_streamer #(
  parameter int NUM_WORDS = 507,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int OFFSET    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_radd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

  localparam logic [ADDR_W-1:0]        LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic signed [DATA_W:0]   OFF_EXT   = (DATA_W + 1)'(OFFSET);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                done_q, done_d;
  logic                inflight_q;
  logic                inflight_last_q;
  logic [DATA_W-1:0]   fifo_data_q [2];
  logic                fifo_last_q [2];
  logic                rd_ptr_q, wr_ptr_q;
  logic [1:0]          count_q, count_d;

  logic                pop;
  logic                issue;
  logic [2:0]          occ_after;
  logic signed [DATA_W:0] sum_ext;
  logic [DATA_W-1:0]   word_adj;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_last  = fifo_last_q[rd_ptr_q];
  assign pop       = out_valid & out_ready;

  // Occupancy once this cycle settles: buffered words plus the read still returning, minus the pop.
  assign occ_after = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == ST_READ) && (occ_after < 3'd2);
  assign count_d   = count_q + {1'b0, inflight_q} - {1'b0, pop};

  assign mem_ren  = issue;
  assign mem_radd = addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

  assign sum_ext = $signed({mem_rdata[DATA_W-1], mem_rdata}) + OFF_EXT;

  always_comb begin
    word_adj = sum_ext[DATA_W-1:0];
`ifdef MAXPOOL_STREAM_SAT_EN
    if (sum_ext[DATA_W] != sum_ext[DATA_W-1]) begin
      word_adj = sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          addr_d  = '0;
        end
      end
      ST_READ: begin
        if (issue) begin
          if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
          else                     addr_d  = addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Nothing buffered or returning after this cycle means the last beat has gone.
        if (occ_after == 3'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      inflight_q <= issue;
      if (issue) inflight_last_q <= (addr_q == LAST_ADDR);
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= word_adj;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_maxpool_rstl_streamer.sv
// Randomized bench for maxpool_rstl_streamer: memory model, expected words from plain integer arithmetic.
module tb_maxpool_rstl_streamer;

  localparam int NW  = 507;
  localparam int AW  = 10;
  localparam int DW  = 8;
  localparam int OFF = 1;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, mem_ren, out_valid, out_ready, out_last;
  logic [AW-1:0] mem_radd;
  logic [DW-1:0] mem_rdata, out_data;

  logic          start1, busy1, done1, mem_ren1, out_valid1, out_ready1, out_last1;
  logic [AW-1:0] mem_radd1;
  logic [DW-1:0] mem_rdata1, out_data1;

  logic [DW-1:0] tb_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_w  [NW];
  logic [DW-1:0] obs_first [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  maxpool_rstl_streamer #(.NUM_WORDS(NW), .ADDR_W(AW), .DATA_W(DW), .OFFSET(OFF)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_ren(mem_ren), .mem_radd(mem_radd), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  maxpool_rstl_streamer #(.NUM_WORDS(1), .ADDR_W(AW), .DATA_W(DW), .OFFSET(OFF)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .mem_ren(mem_ren1), .mem_radd(mem_radd1), .mem_rdata(mem_rdata1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1)
  );

  always @(posedge clk) begin
    if (mem_ren)  mem_rdata  <= tb_mem[mem_radd];
    if (mem_ren1) mem_rdata1 <= tb_mem[mem_radd1];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] m);
    int s;
    s = int'($signed(m)) + OFF;
`ifdef MAXPOOL_STREAM_SAT_EN
    if (s > (1 << (DW-1)) - 1) s = (1 << (DW-1)) - 1;
    if (s < -(1 << (DW-1)))    s = -(1 << (DW-1));
`endif
    return DW'(s);
  endfunction

  // Starts a stream (start sampled at the next rising edge) and checks it beat by beat.
  task automatic run_stream(input int rdy_pct, input int hold, input int abort_at);
    int   beats, issued, last_pop_cyc;
    bit   fin;
    logic pop;
    beats = 0; issued = 0; last_pop_cyc = -10; fin = 0;
    for (int i = 0; i < NW; i++) exp_w[i] = ref_word(tb_mem[i]);
    start = 1'b1;
    for (int cyc = 1; cyc <= 4*NW + 20 && !fin; cyc++) begin
      @(negedge clk);
      start     = (cyc < hold);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (cyc == 1) check_val("radd_first", {31'd0, mem_ren} << 16 | mem_radd, 32'h10000);
      if (cyc == 2) check_val("valid_before_latency", out_valid, 0);
      if (cyc == 3) check_val("first_beat_latency", out_valid, 1);
      if (done) begin
        check_val("done_beat_count", beats, NW);
        check_val("done_timing", cyc, last_pop_cyc + 1);
        check_val("busy_in_done", busy, 0);
        check_val("ren_in_done", mem_ren, 0);
        fin = 1;
      end else begin
        check_val("busy_mid", busy, 1);
        pop = out_valid & out_ready;
        if (mem_ren) begin
          check_val("radd", mem_radd, issued);
          check_val("occupancy_limit", ((issued - beats - int'(pop)) < 2), 1);
          check_val("no_extra_issue", (issued < NW), 1);
          issued++;
        end
        if (rdy_pct == 100 && cyc >= 3 && beats < NW) check_val("no_bubble", out_valid, 1);
        if (pop) begin
          if (beats < NW) begin
            check_val("data", out_data, exp_w[beats]);
            check_val("last", out_last, (beats == NW - 1));
            if (beats < 2) obs_first[beats] = out_data;
          end else begin
            check_val("extra_beat", beats, NW - 1);
          end
          beats++;
          last_pop_cyc = cyc;
          if (beats == abort_at) begin
            rst = 1'b1;
            #1;
            check_val("abort_busy", busy, 0);
            check_val("abort_done", done, 0);
            check_val("abort_ren", mem_ren, 0);
            check_val("abort_radd", mem_radd, 0);
            check_val("abort_valid", out_valid, 0);
            check_val("abort_data", out_data, 0);
            check_val("abort_last", out_last, 0);
            return;
          end
        end
      end
    end
    if (!fin) check_val("stream_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; start1 = 1'b0; out_ready1 = 1'b0;
    for (int i = 0; i < (1 << AW); i++) tb_mem[i] = DW'(i % 100);
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ren", mem_ren, 0);
    check_val("rst_radd", mem_radd, 0);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_data", out_data, 0);
    check_val("rst_last", out_last, 0);
    @(negedge clk);
    rst = 1'b0;

    // Full-rate stream of the i mod 100 pattern.
    run_stream(100, 1, -1);

    // Random words under 50% backpressure.
    @(negedge clk);
    for (int i = 0; i < NW; i++) tb_mem[i] = DW'($urandom);
    run_stream(50, 1, -1);

    // Overflow corner at the positive limit.
    @(negedge clk);
    tb_mem[0] = 8'h7F;
    tb_mem[1] = 8'h80;
    run_stream(100, 1, -1);
`ifdef MAXPOOL_STREAM_SAT_EN
    check_val("edge_word0", obs_first[0], 32'h7F);
`else
    check_val("edge_word0", obs_first[0], 32'h80);
`endif
    check_val("edge_word1", obs_first[1], 32'h81);

    // Reset in the middle of a stream.
    @(negedge clk);
    for (int i = 0; i < NW; i++) tb_mem[i] = DW'(i % 100);
    run_stream(100, 1, 200);
    repeat (2) begin
      @(negedge clk);
      #1;
      check_val("abort_no_done", done, 0);
      check_val("abort_idle", busy, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Start held for 10 cycles, then a back-to-back stream started in the done cycle.
    run_stream(100, 10, -1);
    run_stream(100, 1, -1);
    start = 1'b0;

    // Single-word instance.
    @(negedge clk);
    start1 = 1'b1; out_ready1 = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start1 = 1'b0;
      #1;
      if (cyc == 1) begin
        check_val("w1_ren", mem_ren1, 1);
        check_val("w1_radd", mem_radd1, 0);
      end
      if (cyc == 2) check_val("w1_ren_off", mem_ren1, 0);
      if (cyc <= 3) check_val("w1_busy", busy1, 1);
      if (cyc == 3) begin
        check_val("w1_valid", out_valid1, 1);
        check_val("w1_data", out_data1, ref_word(tb_mem[0]));
        check_val("w1_last", out_last1, 1);
      end
      if (cyc == 4) begin
        check_val("w1_done", done1, 1);
        check_val("w1_busy_done", busy1, 0);
      end else begin
        check_val("w1_no_done", done1, 0);
      end
      if (cyc >= 4) check_val("w1_no_valid", out_valid1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
